pipe_hazard_unit: RTL

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB control in shadow stages, detects
// load-use hazards, drives stall/flush, EX forwarding selects, the ID-stage
// write-back bypass and two saturating performance counters.
module pipe_hazard_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              br_taken,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // EX shadow
  logic              ex_valid_q, ex_rw_q, ex_mr_q, ex_urs_q, ex_urt_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rs_q, ex_rt_q;
  // MEM shadow
  logic              mem_valid_q, mem_rw_q, mem_mr_q;
  logic [REG_AW-1:0] mem_rd_q;
  // WB shadow
  logic              wb_valid_q, wb_rw_q, wb_mr_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, ex_bubble, stall_inc, flush_inc;

  // MEM/WB mem_read is carried for completeness of the shadow but never consumed.
  logic unused_mr;
  assign unused_mr = mem_mr_q ^ wb_mr_q;

  // A stage produces register x if it writes it, unless x is the hard-wired zero.
  function automatic logic match(input logic [REG_AW-1:0] x, input logic rw,
                                 input logic [REG_AW-1:0] rd);
    return rw && (rd == x) && !((ZERO_REG_EN != 0) && (x == '0));
  endfunction

  // Hazard detection and the events that feed the counters.
  always_comb begin
    load_use  = id_valid && ex_mr_q &&
                ((id_uses_rs && match(id_rs, ex_valid_q && ex_rw_q, ex_rd_q)) ||
                 (id_uses_rt && match(id_rt, ex_valid_q && ex_rw_q, ex_rd_q)));
    ex_bubble = br_taken || load_use;
    stall_inc = !hold && !br_taken && load_use;
    flush_inc = !hold && br_taken;
  end

  // Stall/flush outputs; hold dominates, then a taken branch, then load-use.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (reset) begin
      // everything stays quiet while reset is asserted
    end else if (hold) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (br_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  // EX operand forwarding from the frozen-or-advancing shadows; MEM beats WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_urs_q && match(ex_rs_q, mem_valid_q && mem_rw_q, mem_rd_q)) begin
      fwd_a = 2'b01;
    end else if (ex_urs_q && match(ex_rs_q, wb_valid_q && wb_rw_q, wb_rd_q)) begin
      fwd_a = 2'b10;
    end
    if (ex_urt_q && match(ex_rt_q, mem_valid_q && mem_rw_q, mem_rd_q)) begin
      fwd_b = 2'b01;
    end else if (ex_urt_q && match(ex_rt_q, wb_valid_q && wb_rw_q, wb_rd_q)) begin
      fwd_b = 2'b10;
    end
  end

  // ID reads a register that WB is writing this same cycle.
  always_comb begin
    id_byp_a = id_uses_rs && match(id_rs, wb_valid_q && wb_rw_q, wb_rd_q);
    id_byp_b = id_uses_rt && match(id_rt, wb_valid_q && wb_rw_q, wb_rd_q);
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Shadow pipeline advance; a bubble clears every field so it never forwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_urs_q    <= 1'b0;
      ex_urt_q    <= 1'b0;
      ex_rd_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_mr_q     <= 1'b0;
      wb_rd_q     <= '0;
    end else if (!hold) begin
      wb_valid_q  <= mem_valid_q;
      wb_rw_q     <= mem_rw_q;
      wb_mr_q     <= mem_mr_q;
      wb_rd_q     <= mem_rd_q;
      mem_valid_q <= ex_valid_q;
      mem_rw_q    <= ex_rw_q;
      mem_mr_q    <= ex_mr_q;
      mem_rd_q    <= ex_rd_q;
      if (ex_bubble || !id_valid) begin
        ex_valid_q <= 1'b0;
        ex_rw_q    <= 1'b0;
        ex_mr_q    <= 1'b0;
        ex_urs_q   <= 1'b0;
        ex_urt_q   <= 1'b0;
        ex_rd_q    <= '0;
        ex_rs_q    <= '0;
        ex_rt_q    <= '0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_rw_q    <= id_reg_write;
        ex_mr_q    <= id_mem_read;
        ex_urs_q   <= id_uses_rs;
        ex_urt_q   <= id_uses_rt;
        ex_rd_q    <= id_rd;
        ex_rs_q    <= id_rs;
        ex_rt_q    <= id_rt;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
